// File: rtl/duc_cfg_pkg.sv
// Shared constants, address map and FSM state type for the DUC channel configuration bank.
// Optional readback (cfg_rd/cfg_rdata) is built when DUC_CFG_READBACK_EN is defined.
`timescale 1ns/1ps
package duc_cfg_pkg;
  localparam int NUM_FREQ   = 36;
  localparam int FREQ_W     = 10;
  localparam int NUM_BLK    = 3;
  localparam int CH_PER_BLK = 24;
  localparam int MUTE_CYC   = 4;
  localparam int ADDR_W     = 7;
  localparam int DATA_W     = 16;
  localparam int VER_W      = 8;

  localparam int FREQ_BASE  = 0;
  localparam int ENA_BASE   = 36;
  localparam int ERR_CLR    = 127;
  localparam int ENA_LAST   = ENA_BASE + 2 * NUM_BLK - 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUTE,
    ST_APPLY,
    ST_UNMUTE
  } cfg_state_e;

  // True for addresses backed by a shadow register (freq words and enable halves).
  function automatic logic addr_mapped(input logic [ADDR_W-1:0] a);
    return (int'(a) >= FREQ_BASE) && (int'(a) <= ENA_LAST);
  endfunction
endpackage

// File: rtl/duc_chan_cfg_if.sv
// Host configuration bus of the DUC channel configuration bank.
// Readback signals exist only when DUC_CFG_READBACK_EN is defined.
`timescale 1ns/1ps
interface duc_chan_cfg_if;
  import duc_cfg_pkg::*;

  logic              cfg_wr;
  logic [ADDR_W-1:0] cfg_addr;
  logic [DATA_W-1:0] cfg_wdata;
  logic              cfg_commit;
  logic              cfg_busy;
  logic              cfg_err;
  logic [VER_W-1:0]  cfg_ver;
`ifdef DUC_CFG_READBACK_EN
  logic              cfg_rd;
  logic [DATA_W-1:0] cfg_rdata;
`endif

  modport master (
    output cfg_wr, cfg_addr, cfg_wdata, cfg_commit,
`ifdef DUC_CFG_READBACK_EN
    output cfg_rd,
    input  cfg_rdata,
`endif
    input  cfg_busy, cfg_err, cfg_ver
  );

  modport slave (
    input  cfg_wr, cfg_addr, cfg_wdata, cfg_commit,
`ifdef DUC_CFG_READBACK_EN
    input  cfg_rd,
    output cfg_rdata,
`endif
    output cfg_busy, cfg_err, cfg_ver
  );
endinterface

// File: rtl/duc_cfg_regfile.sv
// Shadow register storage and address decode for the DUC channel configuration bank.
// Readback mux/register is built when DUC_CFG_READBACK_EN is defined.
`timescale 1ns/1ps
module duc_cfg_regfile
  import duc_cfg_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_en_i,
  input  logic [ADDR_W-1:0]              addr_i,
  input  logic [DATA_W-1:0]              wdata_i,
`ifdef DUC_CFG_READBACK_EN
  input  logic                           rd_i,
  output logic [DATA_W-1:0]              rdata_o,
`endif
  output logic                           addr_ok_o,
  output logic [NUM_FREQ*FREQ_W-1:0]     freq_shadow_o,
  output logic [NUM_BLK*CH_PER_BLK-1:0]  ena_shadow_o
);

  logic [FREQ_W-1:0]             freq_q [NUM_FREQ];
  logic [NUM_BLK*CH_PER_BLK-1:0] ena_q;

  assign addr_ok_o = addr_mapped(addr_i);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_FREQ; k++) freq_q[k] <= '0;
      ena_q <= '0;
    end else if (wr_en_i) begin
      for (int k = 0; k < NUM_FREQ; k++) begin
        if (addr_i == ADDR_W'(FREQ_BASE + k)) freq_q[k] <= wdata_i[FREQ_W-1:0];
      end
      // Each block owns two addresses: c0..c15 then c16..c23.
      for (int b = 0; b < NUM_BLK; b++) begin
        if (addr_i == ADDR_W'(ENA_BASE + 2 * b))
          ena_q[b*CH_PER_BLK +: 16] <= wdata_i;
        if (addr_i == ADDR_W'(ENA_BASE + 2 * b + 1))
          ena_q[b*CH_PER_BLK+16 +: 8] <= wdata_i[7:0];
      end
    end
  end

  for (genvar gi = 0; gi < NUM_FREQ; gi++) begin : g_freq_flat
    assign freq_shadow_o[gi*FREQ_W +: FREQ_W] = freq_q[gi];
  end

  assign ena_shadow_o = ena_q;

`ifdef DUC_CFG_READBACK_EN
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_d;

  always_comb begin
    rdata_d = '0;
    for (int k = 0; k < NUM_FREQ; k++) begin
      if (addr_i == ADDR_W'(FREQ_BASE + k)) rdata_d = DATA_W'(freq_q[k]);
    end
    for (int b = 0; b < NUM_BLK; b++) begin
      if (addr_i == ADDR_W'(ENA_BASE + 2 * b))
        rdata_d = ena_q[b*CH_PER_BLK +: 16];
      if (addr_i == ADDR_W'(ENA_BASE + 2 * b + 1))
        rdata_d = DATA_W'(ena_q[b*CH_PER_BLK+16 +: 8]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst)       rdata_q <= '0;
    else if (rd_i) rdata_q <= rdata_d;
  end

  assign rdata_o = rdata_q;
`endif

endmodule

// File: rtl/duc_chan_cfg.sv
// DUC channel configuration bank: shadow writes, atomic mute-retune-unmute commit, error/version status.
// Define DUC_CFG_READBACK_EN to add shadow readback (cfg_rd/cfg_rdata) on the host bus.
`timescale 1ns/1ps
module duc_chan_cfg
  import duc_cfg_pkg::*;
(
  input  logic                           clk_1,
  input  logic                           rst,
  input  logic                           ce_1,
  duc_chan_cfg_if.slave                  bus,
  output logic [NUM_FREQ*FREQ_W-1:0]     freq_word_bus,
  output logic [NUM_BLK*CH_PER_BLK-1:0]  ena_bus
);

  localparam int CNT_W = $clog2(MUTE_CYC + 1);

  cfg_state_e                    state_q, state_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [NUM_FREQ*FREQ_W-1:0]    freq_q, freq_d;
  logic [NUM_BLK*CH_PER_BLK-1:0] ena_q, ena_d;
  logic [VER_W-1:0]              ver_q, ver_d;
  logic                          err_q, err_d;

  logic                          busy;
  logic                          addr_ok;
  logic                          is_clr;
  logic                          err_set;
  logic                          err_clr;
  logic [NUM_FREQ*FREQ_W-1:0]    freq_shadow;
  logic [NUM_BLK*CH_PER_BLK-1:0] ena_shadow;

  assign busy   = (state_q != ST_IDLE);
  assign is_clr = (bus.cfg_addr == ADDR_W'(ERR_CLR));

  duc_cfg_regfile u_regfile (
    .clk           (clk_1),
    .rst           (rst),
    .wr_en_i       (bus.cfg_wr && !busy),
    .addr_i        (bus.cfg_addr),
    .wdata_i       (bus.cfg_wdata),
`ifdef DUC_CFG_READBACK_EN
    .rd_i          (bus.cfg_rd),
    .rdata_o       (bus.cfg_rdata),
`endif
    .addr_ok_o     (addr_ok),
    .freq_shadow_o (freq_shadow),
    .ena_shadow_o  (ena_shadow)
  );

  // The clear address is honoured even while busy; every other busy write is an error.
  always_comb begin
    err_set = (bus.cfg_wr && !is_clr && (busy || !addr_ok))
            || (bus.cfg_commit && busy);
`ifdef DUC_CFG_READBACK_EN
    err_set = err_set || (bus.cfg_rd && !addr_ok);
`endif
    err_clr = bus.cfg_wr && is_clr;
    err_d   = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    freq_d  = freq_q;
    ena_d   = ena_q;
    ver_d   = ver_q;
    case (state_q)
      ST_IDLE: begin
        // Muting happens on the commit edge itself, independent of ce_1.
        if (bus.cfg_commit) begin
          state_d = ST_MUTE;
          ena_d   = '0;
          cnt_d   = '0;
        end
      end
      ST_MUTE: begin
        if (ce_1) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(MUTE_CYC - 1)) state_d = ST_APPLY;
        end
      end
      ST_APPLY: begin
        if (ce_1) begin
          freq_d  = freq_shadow;
          state_d = ST_UNMUTE;
        end
      end
      ST_UNMUTE: begin
        if (ce_1) begin
          ena_d   = ena_shadow;
          ver_d   = ver_q + 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_1) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      freq_q  <= '0;
      ena_q   <= '0;
      ver_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      freq_q  <= freq_d;
      ena_q   <= ena_d;
      ver_q   <= ver_d;
      err_q   <= err_d;
    end
  end

  assign bus.cfg_busy  = busy;
  assign bus.cfg_err   = err_q;
  assign bus.cfg_ver   = ver_q;
  assign freq_word_bus = freq_q;
  assign ena_bus       = ena_q;

endmodule
